// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine. The control unit
// imports this package for its wait states and the mfhi/mflo mux selects.
package muldiv_pkg;

    // Operation select, sampled together with start.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Native datapath width. Engine instances use WIDTH <= DATA_W.
    localparam int DATA_W = 32;
    localparam int ITER_W = $clog2(DATA_W);
    localparam int MAX_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2,
        ST_DZERO  = 2'd3
    } state_t;

    // Two's-complement negate when en is set. Callers zero-extend narrower values
    // and keep only the low bits, which stay correct modulo 2^width.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide engine owning HI/LO. One radix-2 step per
// clock on operand magnitudes, followed by a single sign-correction cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t              state;
    logic [ITER_W-1:0]   counter;
    logic [2*WIDTH-1:0]  acc;      // mult: {partial product}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]    mag_op;   // mult: |a| (addend); div: |b| (divisor)
    logic                op_r;
    logic                sign_q;   // result / quotient must be negated
    logic                sign_r;   // remainder must be negated

    logic [MAX_W-1:0]    abs_a_w;
    logic [MAX_W-1:0]    abs_b_w;
    logic [MAX_W-1:0]    prod_fix_w;
    logic [MAX_W-1:0]    quo_fix_w;
    logic [MAX_W-1:0]    rem_fix_w;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_trial;
    logic [WIDTH+1:0]    div_diff;
    logic                div_borrow;
    logic [WIDTH-1:0]    div_rem;
    logic [2*WIDTH-1:0]  acc_next;
    logic                last_step;

    // Upper bits of the widened helper results are don't-care.
    logic unused_bits;
    assign unused_bits = ^{abs_a_w[MAX_W-1:WIDTH], abs_b_w[MAX_W-1:WIDTH],
                           quo_fix_w[MAX_W-1:WIDTH], rem_fix_w[MAX_W-1:WIDTH], div_diff[WIDTH]};

    assign last_step = (counter == ITER_W'(WIDTH - 1));

    // Operand magnitudes, one iteration step, and final sign correction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_next   = acc;
        abs_a_w    = cond_neg(MAX_W'(a), a[WIDTH-1]);
        abs_b_w    = cond_neg(MAX_W'(b), b[WIDTH-1]);
        prod_fix_w = cond_neg(MAX_W'(acc), sign_q);
        quo_fix_w  = cond_neg(MAX_W'(acc[WIDTH-1:0]), sign_q);
        rem_fix_w  = cond_neg(MAX_W'(acc[2*WIDTH-1:WIDTH]), sign_r);

        // Shift-add: add the multiplicand into the upper half when the LSB is set, then shift right.
        mul_sum    = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_op})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};

        // Restoring divide: shift in the next dividend bit, keep the difference if no borrow.
        div_trial  = acc[2*WIDTH-1:WIDTH-1];
        div_diff   = {1'b0, div_trial} - {2'b00, mag_op};
        div_borrow = div_diff[WIDTH+1];
        div_rem    = div_borrow ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];

        if (op_r == OP_MULT) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {div_rem, acc[WIDTH-2:0], ~div_borrow};
        end
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            counter  <= '0;
            acc      <= '0;
            mag_op   <= '0;
            op_r     <= OP_MULT;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op == OP_DIV && b == '0) begin
                            state <= ST_DZERO;
                        end else begin
                            state   <= ST_CALC;
                            counter <= '0;
                            op_r    <= op;
                            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r  <= a[WIDTH-1];
                            if (op == OP_MULT) begin
                                mag_op <= abs_a_w[WIDTH-1:0];
                                acc    <= {{WIDTH{1'b0}}, abs_b_w[WIDTH-1:0]};
                            end else begin
                                mag_op <= abs_b_w[WIDTH-1:0];
                                acc    <= {{WIDTH{1'b0}}, abs_a_w[WIDTH-1:0]};
                            end
                        end
                    end
                end
                ST_CALC: begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                    if (last_step) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (op_r == OP_MULT) begin
                        hi <= prod_fix_w[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_w[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix_w[WIDTH-1:0];
                        lo <= quo_fix_w[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_DZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, sign handling, divide by zero,
// ignored starts while busy, back-to-back issue and mid-operation reset.
module tb_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    // Last hi/lo values the bench expects the engine to hold between operations.
    logic [31:0] hold_hi = 32'h0;
    logic [31:0] hold_lo = 32'h0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, check busy through the 32 CALC edges (with a stray
    // start at edge 5 that must be ignored), then check the result after edge 33.
    task automatic run_op(input string tag, input logic o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0;
        check($sformatf("%s busy@E0", tag), {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                start = 1'b1; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0;
            end
            tick();
            if (k == 5) start = 1'b0;
            check($sformatf("%s busy@E%0d", tag, k), {31'b0, busy}, 32'd1);
            check($sformatf("%s done@E%0d", tag, k), {31'b0, done}, 32'd0);
            if (k == 16) begin
                check($sformatf("%s hi_hold", tag), hi, hold_hi);
                check($sformatf("%s lo_hold", tag), lo, hold_lo);
            end
        end
        tick();
        check($sformatf("%s done@E33", tag), {31'b0, done}, 32'd1);
        check($sformatf("%s busy@E33", tag), {31'b0, busy}, 32'd0);
        check($sformatf("%s dz@E33", tag), {31'b0, div_zero}, 32'd0);
        check($sformatf("%s hi", tag), hi, eh);
        check($sformatf("%s lo", tag), lo, el);
        hold_hi = eh;
        hold_lo = el;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
        #12;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst dz", {31'b0, div_zero}, 32'd0);
        check("rst hi", hi, 32'h0);
        check("rst lo", lo, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 7 * -3 = -21
        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        check("mul_7_m3 done_drop", {31'b0, done}, 32'd0);
        check("mul_7_m3 hi_keep", hi, 32'hFFFF_FFFF);
        check("mul_7_m3 lo_keep", lo, 32'hFFFF_FFEB);

        // (-2^31) * (-2^31) = 2^62
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        tick();

        // -7 / 2 = -3 rem -1
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();

        // 100 / -7 = -14 rem 2
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        tick();

        // -2^31 / -1 wraps to -2^31 rem 0
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Back-to-back: start issued in the done cycle; -5 * -6 = 30
        run_op("b2b_mul", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E);
        tick();

        // Divide by zero: done/div_zero after E1, hi/lo untouched
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
        tick();
        start = 1'b0;
        check("dz busy@E0", {31'b0, busy}, 32'd1);
        check("dz done@E0", {31'b0, done}, 32'd0);
        tick();
        check("dz done@E1", {31'b0, done}, 32'd1);
        check("dz flag@E1", {31'b0, div_zero}, 32'd1);
        check("dz busy@E1", {31'b0, busy}, 32'd0);
        check("dz hi", hi, hold_hi);
        check("dz lo", lo, hold_lo);
        tick();
        check("dz done_drop", {31'b0, done}, 32'd0);
        check("dz flag_drop", {31'b0, div_zero}, 32'd0);

        // Reset at edge 10 of a mult aborts it and clears everything at once
        start = 1'b1; op = 1'b0; a = 32'd123; b = 32'd456;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst busy", {31'b0, busy}, 32'd0);
        check("mid_rst done", {31'b0, done}, 32'd0);
        check("mid_rst dz", {31'b0, div_zero}, 32'd0);
        check("mid_rst hi", hi, 32'h0);
        check("mid_rst lo", lo, 32'h0);
        hold_hi = 32'h0;
        hold_lo = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 123 * 456 = 56088 after the aborted run
        run_op("mul_after_rst", 1'b0, 32'd123, 32'd456, 32'h0, 32'h0000_DB18);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
